collision_detector: RTL and testbench
=====================================

COLLISION_DETECTOR -- requirements
Module: collision_detector

Interface
REQ-001 SHALL have parameter PLAYER_SIZE, default 10: side of the square player hitbox, in pixels.
REQ-002 SHALL have parameter HP_MAX, default 4: lives at game start (1..7).
REQ-003 SHALL have parameter INVULN_CYCLES, default 65000000: post-hit immunity length in pclk cycles (1 s at 65 MHz).
REQ-004 SHALL have parameter BLINK_CYCLES, default 4062500: half-period of the cursor blink during immunity.
REQ-005 SHALL have port pclk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port game_on, input, 1 bit: game running; low means menu.
REQ-008 SHALL have port obstacle_x, input, 12 bits: current obstacle pixel x; 0 with obstacle_y 0 means no obstacle pixel.
REQ-009 SHALL have port obstacle_y, input, 12 bits: current obstacle pixel y.
REQ-010 SHALL have port mouse_xpos, input, 12 bits: top-left x of the player hitbox.
REQ-011 SHALL have port mouse_ypos, input, 12 bits: top-left y of the player hitbox.
REQ-012 SHALL have port hit, output, 1 bit: one-cycle pulse per registered damage.
REQ-013 SHALL have port hp, output, 3 bits: remaining lives.
REQ-014 SHALL have port invuln, output, 1 bit: immunity active.
REQ-015 SHALL have port cursor_visible, output, 1 bit: drawing enable for the cursor (blinks during immunity).
REQ-016 SHALL have port game_over, output, 1 bit: level, hp exhausted.

Function
REQ-017 Overlap SHALL be (obstacle_x!=0 || obstacle_y!=0) && mouse_xpos<=obstacle_x<=mouse_xpos+PLAYER_SIZE-1 && mouse_ypos<=obstacle_y<=mouse_ypos+PLAYER_SIZE-1.
REQ-018 The upper bounds SHALL be computed 13 bits wide; no wrap at 4095.
REQ-019 Overlap SHALL be registered into a match flag (stage 1); the FSM SHALL act on the flag (stage 2); hit rises exactly 2 cycles after the obstacle coordinate is presented.
REQ-020 FSM states SHALL be IDLE, ARMED, INVULN, DEAD.
REQ-021 IDLE: hp=HP_MAX, invuln=0, game_over=0, cursor_visible=1; game_on=1 -> ARMED.
REQ-022 ARMED: match=1 -> hit=1 for one cycle, hp decrements; if hp was 1 -> DEAD, otherwise -> INVULN with the immunity counter cleared.
REQ-023 INVULN: invuln=1; matches ignored (no hit, no hp change); counter increments each cycle; at count INVULN_CYCLES-1 -> ARMED.
REQ-024 INVULN blink: cursor_visible starts at 0 on entry and toggles every BLINK_CYCLES cycles; cursor_visible=1 in all other states.
REQ-025 DEAD: game_over=1, hp=0, hit=0; held until game_on=0.
REQ-026 game_on=0 in any state SHALL force IDLE on the next edge, reload hp=HP_MAX, and clear both counters; this takes priority over a simultaneous match (no hit).
REQ-027 Back-to-back matching pixels in ARMED SHALL produce exactly one hit, because the next cycle is already INVULN.
REQ-028 hp SHALL never underflow below 0 and never exceed HP_MAX.
REQ-029 The match pipeline register SHALL be cleared whenever the state is IDLE.

Reset
REQ-030 rst=1 SHALL asynchronously force: state=IDLE, match=0, hit=0, hp=HP_MAX, invuln=0, cursor_visible=1, game_over=0, immunity and blink counters=0.
REQ-031 Reset mid-INVULN or in DEAD SHALL abort immediately; the first post-reset hit requires game_on=1 and a fresh match.

Verification (bench: PLAYER_SIZE=10, HP_MAX=3, INVULN_CYCLES=16, BLINK_CYCLES=4)
REQ-032 Edge hit: game_on=1, mouse=(400,400), one-cycle obstacle=(409,409) -> hit pulse 2 cycles later, hp 3->2, invuln=1 for 16 cycles, cursor_visible pattern 0000111100001111, then ARMED.
REQ-033 Miss and null: obstacle=(410,405), then (399,405), then (0,0) with mouse=(0,0) -> no hit, hp stays 3.
REQ-034 Immunity: hit, then obstacle=(405,405) held for 10 cycles -> exactly one hit total, hp=2.
REQ-035 Death: three hits, each spaced 20 cycles -> hp 3,2,1,0, game_over=1 after the third; later matches produce no hit; game_on=0 -> IDLE, hp=3, game_over=0.
REQ-036 Priority/wrap: mouse=(4090,4090), obstacle=(4095,4095) -> hit; match coincident with game_on falling -> no hit, hp=3.
REQ-037 Async reset: assert rst mid-INVULN between clock edges -> outputs take reset values before the next edge.

Source files
------------

// File: rtl/collision_detector.sv
`default_nettype none
// ============================================================================
//  Module   : collision_detector
//  Brief    : Player/obstacle hit detection with lives, post-hit immunity
//             and cursor blink. Stage 1 registers a pixel overlap flag.
//             Stage 2 is the game FSM that consumes the flag.
//  Revision : 1.0  initial release
// ============================================================================
module collision_detector #(
  parameter int PLAYER_SIZE   = 10,
  parameter int HP_MAX        = 4,
  parameter int INVULN_CYCLES = 65000000,
  parameter int BLINK_CYCLES  = 4062500
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        game_on,
  input  logic [11:0] obstacle_x,
  input  logic [11:0] obstacle_y,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  output logic        hit,
  output logic [2:0]  hp,
  output logic        invuln,
  output logic        cursor_visible,
  output logic        game_over
);

  localparam int c_INV_W = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
  localparam int c_BLK_W = (BLINK_CYCLES  > 1) ? $clog2(BLINK_CYCLES)  : 1;

  localparam logic [c_INV_W-1:0] c_INV_LAST = c_INV_W'(INVULN_CYCLES - 1);
  localparam logic [c_INV_W-1:0] c_INV_ONE  = c_INV_W'(1);
  localparam logic [c_BLK_W-1:0] c_BLK_LAST = c_BLK_W'(BLINK_CYCLES - 1);
  localparam logic [c_BLK_W-1:0] c_BLK_ONE  = c_BLK_W'(1);
  localparam logic [2:0]         c_HP_MAX   = 3'(HP_MAX);
  localparam logic [12:0]        c_SPAN     = 13'(PLAYER_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    INVULN = 2'd2,
    DEAD   = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_match;
  logic [c_INV_W-1:0] r_inv_cnt;
  logic [c_BLK_W-1:0] r_blink_cnt;

  logic        w_pixel_valid;
  logic [12:0] w_x_hi;
  logic [12:0] w_y_hi;
  logic        w_overlap;

  // Hitbox upper bounds are one bit wider so a box near 4095 does not wrap to 0.
  assign w_pixel_valid = (obstacle_x != 12'd0) || (obstacle_y != 12'd0);
  assign w_x_hi        = {1'b0, mouse_xpos} + c_SPAN;
  assign w_y_hi        = {1'b0, mouse_ypos} + c_SPAN;
  assign w_overlap     = w_pixel_valid
                       && (obstacle_x >= mouse_xpos) && ({1'b0, obstacle_x} <= w_x_hi)
                       && (obstacle_y >= mouse_ypos) && ({1'b0, obstacle_y} <= w_y_hi);

  // Stage 1: register the overlap; held clear while the game is idle or stopping.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_match <= 1'b0;
    end else if ((r_state == IDLE) || !game_on) begin
      r_match <= 1'b0;
    end else begin
      r_match <= w_overlap;
    end
  end

  // Stage 2: game FSM with registered outputs; leaving the game wins over any hit.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_inv_cnt      <= '0;
      r_blink_cnt    <= '0;
      hit            <= 1'b0;
      hp             <= c_HP_MAX;
      invuln         <= 1'b0;
      cursor_visible <= 1'b1;
      game_over      <= 1'b0;
    end else begin
      hit <= 1'b0;
      if (!game_on) begin
        r_state        <= IDLE;
        r_inv_cnt      <= '0;
        r_blink_cnt    <= '0;
        hp             <= c_HP_MAX;
        invuln         <= 1'b0;
        cursor_visible <= 1'b1;
        game_over      <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            hp             <= c_HP_MAX;
            invuln         <= 1'b0;
            cursor_visible <= 1'b1;
            game_over      <= 1'b0;
            r_state        <= ARMED;
          end
          ARMED: begin
            if (r_match && (hp != 3'd0)) begin
              hit <= 1'b1;
              hp  <= hp - 3'd1;
              if (hp == 3'd1) begin
                r_state        <= DEAD;
                game_over      <= 1'b1;
                invuln         <= 1'b0;
                cursor_visible <= 1'b1;
              end else begin
                r_state        <= INVULN;
                r_inv_cnt      <= '0;
                r_blink_cnt    <= '0;
                invuln         <= 1'b1;
                cursor_visible <= 1'b0;
              end
            end
          end
          INVULN: begin
            if (r_inv_cnt == c_INV_LAST) begin
              r_state        <= ARMED;
              r_inv_cnt      <= '0;
              r_blink_cnt    <= '0;
              invuln         <= 1'b0;
              cursor_visible <= 1'b1;
            end else begin
              r_inv_cnt <= r_inv_cnt + c_INV_ONE;
              if (r_blink_cnt == c_BLK_LAST) begin
                r_blink_cnt    <= '0;
                cursor_visible <= ~cursor_visible;
              end else begin
                r_blink_cnt <= r_blink_cnt + c_BLK_ONE;
              end
            end
          end
          DEAD: begin
            hp        <= 3'd0;
            game_over <= 1'b1;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_collision_detector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_collision_detector
//  Brief    : Directed self-checking bench for collision_detector.
//  Revision : 1.0  initial release
// ============================================================================
module tb_collision_detector;

  logic        pclk = 1'b0;
  logic        rst;
  logic        game_on;
  logic [11:0] obstacle_x, obstacle_y, mouse_xpos, mouse_ypos;
  logic        hit;
  logic [2:0]  hp;
  logic        invuln, cursor_visible, game_over;

  int n_tests = 0;
  int n_fail  = 0;

  collision_detector #(
    .PLAYER_SIZE(10), .HP_MAX(3), .INVULN_CYCLES(16), .BLINK_CYCLES(4)
  ) dut (
    .pclk(pclk), .rst(rst), .game_on(game_on),
    .obstacle_x(obstacle_x), .obstacle_y(obstacle_y),
    .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
    .hit(hit), .hp(hp), .invuln(invuln),
    .cursor_visible(cursor_visible), .game_over(game_over)
  );

  always #5 pclk = ~pclk;

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic obst(input int x, input int y);
    obstacle_x = 12'(x);
    obstacle_y = 12'(y);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hit"},    32'(hit), 0);
    chk({tag, "_hp"},     32'(hp), 3);
    chk({tag, "_invuln"}, 32'(invuln), 0);
    chk({tag, "_cursor"}, 32'(cursor_visible), 1);
    chk({tag, "_gover"},  32'(game_over), 0);
  endtask

  // One-cycle matching pixel at (405,405) with mouse at (400,400); returns after hit edge.
  task automatic single_hit(input int exp_hp, input string tag);
    obst(405, 405);
    step();
    obst(0, 0);
    step();
    chk({tag, "_hit"}, 32'(hit), 1);
    chk({tag, "_hp"},  32'(hp), 32'(exp_hp));
  endtask

  initial begin
    int          hits;
    logic [15:0] pat;
    pat = 16'b0000111100001111;

    rst = 1'b1; game_on = 1'b0;
    obst(0, 0);
    mouse_xpos = 12'd0; mouse_ypos = 12'd0;
    step(); step();
    chk_reset_vals("reset");
    rst = 1'b0;
    step();

    // Edge hit at the far corner of the hitbox
    mouse_xpos = 12'd400; mouse_ypos = 12'd400;
    game_on = 1'b1;
    step();                               // IDLE -> ARMED
    obst(409, 409);
    step();
    chk("edge_hit_early", 32'(hit), 0);
    obst(0, 0);
    step();
    chk("edge_hit_pulse", 32'(hit), 1);
    chk("edge_hp", 32'(hp), 2);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("inv_%0d", i), 32'(invuln), 1);
      chk($sformatf("blink_%0d", i), 32'(cursor_visible), 32'(pat[15-i]));
      chk($sformatf("hit_len_%0d", i), 32'(hit), (i == 0) ? 1 : 0);
      step();
    end
    chk("inv_end", 32'(invuln), 0);
    chk("cursor_end", 32'(cursor_visible), 1);

    // Back to menu reloads lives
    game_on = 1'b0;
    step();
    chk("menu_hp", 32'(hp), 3);
    game_on = 1'b1;
    step();

    // Misses just outside the box and the null pixel
    obst(410, 405); step(); chk("miss_x_hi", 32'(hit), 0);
    obst(399, 405); step(); chk("miss_x_lo", 32'(hit), 0);
    mouse_xpos = 12'd0; mouse_ypos = 12'd0;
    obst(0, 0);     step(); chk("null_a", 32'(hit), 0);
    step();         chk("null_b", 32'(hit), 0);
    step();         chk("null_c", 32'(hit), 0);
    chk("miss_hp", 32'(hp), 3);

    // Held obstacle during immunity yields a single hit
    mouse_xpos = 12'd400; mouse_ypos = 12'd400;
    hits = 0;
    obst(405, 405);
    for (int i = 0; i < 12; i++) begin
      if (i == 10) obst(0, 0);
      step();
      if (hit) hits++;
    end
    chk("immune_hits", 32'(hits), 1);
    chk("immune_hp", 32'(hp), 2);
    chk("immune_inv", 32'(invuln), 1);
    repeat (20) step();
    chk("immune_over", 32'(invuln), 0);

    // Death sequence
    game_on = 1'b0; step();
    chk("death_hp3", 32'(hp), 3);
    game_on = 1'b1; step();
    single_hit(2, "death1"); repeat (18) step();
    single_hit(1, "death2"); repeat (18) step();
    single_hit(0, "death3");
    chk("death_gover", 32'(game_over), 1);
    chk("death_inv", 32'(invuln), 0);
    chk("death_cursor", 32'(cursor_visible), 1);
    obst(405, 405);
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (hit) hits++;
    end
    obst(0, 0);
    chk("dead_no_hit", 32'(hits), 0);
    chk("dead_hp", 32'(hp), 0);
    chk("dead_gover_held", 32'(game_over), 1);
    game_on = 1'b0; step();
    chk("revive_hp", 32'(hp), 3);
    chk("revive_gover", 32'(game_over), 0);

    // No wrap at the screen edge
    game_on = 1'b1; step();
    mouse_xpos = 12'd4090; mouse_ypos = 12'd4090;
    obst(4095, 4095); step();
    obst(0, 0);       step();
    chk("wrap_hit", 32'(hit), 1);
    chk("wrap_hp", 32'(hp), 2);
    repeat (18) step();
    chk("wrap_armed", 32'(invuln), 0);

    // Match coincident with game_on falling
    obst(4092, 4092); step();             // match registered
    obst(0, 0);
    game_on = 1'b0; step();
    chk("prio_hit", 32'(hit), 0);
    chk("prio_hp", 32'(hp), 3);

    // Asynchronous reset in the middle of immunity
    mouse_xpos = 12'd400; mouse_ypos = 12'd400;
    game_on = 1'b1; step();
    single_hit(2, "arst_pre");
    repeat (3) step();
    chk("arst_inv_before", 32'(invuln), 1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("arst");
    step();
    rst = 1'b0;
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (hit) hits++;
    end
    chk("arst_no_hit", 32'(hits), 0);
    chk("arst_hp", 32'(hp), 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
